// File: rtl/player_pkg.sv
// rtl/player_pkg.sv - opcodes, direction codes, dodge-box geometry and position step helpers
package player_pkg;

  localparam int BOX_X0  = 220;
  localparam int BOX_Y0  = 240;
  localparam int BOX_X1  = 420;
  localparam int BOX_Y1  = 400;
  localparam int PSIZE   = 16;
  localparam int STEP    = 4;
  localparam int MAX_HP  = 100;
  localparam int IFRAMES = 60;

  localparam logic [9:0] X_MIN = 10'(BOX_X0);
  localparam logic [9:0] Y_MIN = 10'(BOX_Y0);
  localparam logic [9:0] X_MAX = 10'(BOX_X1 - PSIZE);
  localparam logic [9:0] Y_MAX = 10'(BOX_Y1 - PSIZE);
  localparam logic [9:0] CX    = 10'((BOX_X0 + BOX_X1 - PSIZE) / 2);
  localparam logic [9:0] CY    = 10'((BOX_Y0 + BOX_Y1 - PSIZE) / 2);

  localparam logic [3:0] OP_HPY = 4'b0001;
  localparam logic [3:0] OP_DPY = 4'b0010;
  localparam logic [3:0] OP_IDG = 4'b0011;
  localparam logic [3:0] OP_SDG = 4'b0100;
  localparam logic [3:0] OP_MOV = 4'b0101;
  localparam logic [3:0] OP_SHP = 4'b0110;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MOVING} state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pos_t;

  // True when one more pixel in dir keeps the sprite inside the box.
  function automatic logic can_step(pos_t p, logic [1:0] dir);
    case (dir)
      DIR_UP:   can_step = (p.y > Y_MIN);
      DIR_LEFT: can_step = (p.x > X_MIN);
      DIR_DOWN: can_step = (p.y < Y_MAX);
      default:  can_step = (p.x < X_MAX);
    endcase
  endfunction

  function automatic pos_t step_pos(pos_t p, logic [1:0] dir);
    step_pos = p;
    case (dir)
      DIR_UP:   step_pos.y = p.y - 10'd1;
      DIR_LEFT: step_pos.x = p.x - 10'd1;
      DIR_DOWN: step_pos.y = p.y + 10'd1;
      default:  step_pos.x = p.x + 10'd1;
    endcase
  endfunction

endpackage

// File: rtl/iframe_timer.sv
// rtl/iframe_timer.sv - damage invulnerability frame counter
module iframe_timer
  import player_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  input  logic frameTick,
  output logic invuln
);

  logic [6:0] cnt;

  // A load on the same cycle as a frame tick restarts the full window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= 7'(IFRAMES);
    else if (clear)
      cnt <= '0;
    else if (frameTick && cnt != '0)
      cnt <= cnt - 7'd1;
  end

  assign invuln = (cnt != '0);

endmodule

// File: rtl/player_executor.sv
// rtl/player_executor.sv - player instruction decoder/executor: position, HP, death, visibility
module player_executor
  import player_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic        instValid,
  output logic        instReady,
  input  logic        frameTick,
  output logic [9:0]  playerX,
  output logic [9:0]  playerY,
  output logic [7:0]  playerHP,
  output logic        isDeath,
  output logic        isMove,
  output logic        visible,
  output logic        invuln,
  output logic        illegalOp
);

  state_t     state, nxt_state;
  logic [3:0] op_q;
  logic [7:0] arg_q;
  pos_t       pos;
  logic [7:0] hp;
  logic       death, active, vis;
  logic [2:0] mv_cnt;
  logic [1:0] dir;
  logic       step_ok, step_more, dpy_take, sdg_exec, unused_rsvd;

  assign dir         = arg_q[1:0];
  assign step_ok     = can_step(pos, dir);
  assign step_more   = can_step(step_pos(pos, dir), dir);
  assign dpy_take    = (state == ST_EXEC) && (op_q == OP_DPY) && active && !invuln && !death;
  assign sdg_exec    = (state == ST_EXEC) && (op_q == OP_SDG);
  assign unused_rsvd = ^instruction[3:0];

  iframe_timer u_iframe (
    .clk       (clk),
    .reset     (reset),
    .load      (dpy_take),
    .clear     (sdg_exec),
    .frameTick (frameTick),
    .invuln    (invuln)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt_state;
  end

  // A move ends when its budget is spent or the following pixel would leave the box.
  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE:   if (instValid) nxt_state = ST_EXEC;
      ST_EXEC:   nxt_state = (op_q == OP_MOV && active && !death) ? ST_MOVING : ST_IDLE;
      ST_MOVING: if (!step_ok || !step_more || mv_cnt == 3'(STEP - 1)) nxt_state = ST_IDLE;
      default:   nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    instReady = (state == ST_IDLE);
    isMove    = (state == ST_MOVING);
    illegalOp = (state == ST_EXEC) && (op_q == 4'd0 || op_q > OP_SHP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      arg_q  <= '0;
      pos    <= '{x: CX, y: CY};
      hp     <= 8'(MAX_HP);
      death  <= 1'b0;
      active <= 1'b0;
      vis    <= 1'b0;
      mv_cnt <= '0;
    end else begin
      if (state == ST_IDLE && instValid) begin
        op_q  <= instruction[15:12];
        arg_q <= instruction[11:4];
      end
      if (state == ST_EXEC) begin
        case (op_q)
          OP_HPY: begin
            hp    <= (arg_q > 8'(MAX_HP)) ? 8'(MAX_HP) : arg_q;
            death <= (arg_q == 8'd0);
          end
          OP_DPY: if (dpy_take) begin
            if (arg_q >= hp) begin
              hp    <= 8'd0;
              death <= 1'b1;
            end else begin
              hp <= hp - arg_q;
            end
          end
          OP_IDG: begin
            active <= 1'b1;
            vis    <= 1'b1;
            pos    <= '{x: CX, y: CY};
          end
          OP_SDG: begin
            active <= 1'b0;
            vis    <= 1'b0;
          end
          OP_MOV:  mv_cnt <= '0;
          OP_SHP:  vis    <= arg_q[0];
          default: ;
        endcase
      end
      if (state == ST_MOVING && step_ok) begin
        pos    <= step_pos(pos, dir);
        mv_cnt <= mv_cnt + 3'd1;
      end
    end
  end

  assign playerX  = pos.x;
  assign playerY  = pos.y;
  assign playerHP = hp;
  assign isDeath  = death;
  assign visible  = vis;

endmodule
